// File: rtl/mult_div_unit_if.sv
// Operand/result bus between execute-stage control and the mult/div unit.
// The master drives the request; the slave returns HI/LO and the busy/done handshake.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  OP;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  modport master (output start, OP, A, B, input HI, LO, busy, done);
  modport slave  (input start, OP, A, B, output HI, LO, busy, done);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with MTHI/MTLO into architectural HI/LO.
// Define MULDIV_FAST_MULT_EN to compute MULT/MULTU with a single-cycle multiplier.
module mult_div_unit (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div, sgn_q, sgn_r, dz;
  logic [31:0] opa, opb;
  logic [63:0] acc;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic signed [31:0] a_s, b_s;
  logic        start_md, start_mt, signed_op, fast_mul;
  logic [31:0] mag_a, mag_b;
  logic [63:0] fast_prod;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;
  logic [63:0] mul_step, div_step, prod;
  logic [31:0] res_hi, res_lo;
  logic        busy_c;

  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
    return (sgn && v[31]) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  assign a_s       = bus.A;
  assign b_s       = bus.B;
  assign start_md  = bus.start && !bus.OP[2];
  assign start_mt  = bus.start && (bus.OP[2:1] == 2'b10);
  assign signed_op = !bus.OP[0];
  assign mag_a     = mag32(a_s, signed_op);
  assign mag_b     = mag32(b_s, signed_op);

`ifdef MULDIV_FAST_MULT_EN
  assign fast_mul  = !bus.OP[1];
  assign fast_prod = {32'd0, mag_a} * {32'd0, mag_b};
`else
  assign fast_mul  = 1'b0;
  assign fast_prod = 64'd0;
`endif

  // Shift-add multiply: multiplier sits in acc[31:0] and is consumed LSB first.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
  assign mul_step = {mul_sum, acc[31:1]};

  // Restoring divide: remainder in acc[63:32], dividend/quotient shifting through acc[31:0].
  assign rem_sh   = acc[63:31];
  assign div_diff = {1'b0, rem_sh} - {2'b00, opb};
  assign div_step = div_diff[33] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

  assign prod = neg64(acc, sgn_q);

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      // Divide by zero naturally leaves |A| as remainder; only the quotient is forced.
      res_hi = neg32(acc[63:32], sgn_r);
      res_lo = dz ? 32'hFFFF_FFFF : neg32(acc[31:0], sgn_q);
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = (state != IDLE);
    case (state)
      IDLE: if (start_md) state_nxt = fast_mul ? FIX : RUN;
      RUN:  if (cnt == 5'd31) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == FIX);
      if (state == IDLE && start_md)
        cnt <= 5'd0;
      else if (state == RUN)
        cnt <= cnt + 5'd1;
      if (state == FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state == IDLE && start_mt) begin
        if (!bus.OP[0]) hi_q <= bus.A;
        else            lo_q <= bus.A;
      end
    end
  end

  always_ff @(posedge clock) begin
    case (state)
      IDLE: if (start_md) begin
        is_div <= bus.OP[1];
        opa    <= mag_a;
        opb    <= mag_b;
        sgn_q  <= signed_op && (bus.A[31] ^ bus.B[31]);
        sgn_r  <= signed_op && bus.A[31];
        dz     <= (bus.B == 32'd0);
        acc    <= fast_mul ? fast_prod : (bus.OP[1] ? {32'd0, mag_a} : {32'd0, mag_b});
      end
      RUN: acc <= is_div ? div_step : mul_step;
      default: ;
    endcase
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.busy = busy_c;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, handshake and interference.
module tb_mult_div_unit;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Issues one request (sampled at the next edge) and waits, bounded, for busy to drop.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output bit overlap);
    bus.start = 1'b1; bus.OP = op; bus.A = a; bus.B = b;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    cyc = 0; overlap = 1'b0;
    while (bus.busy && cyc < 200) begin
      if (bus.done) overlap = 1'b1;
      cyc++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (bus.HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=%h", bus.HI, 32'd0); end
    total++; if (bus.LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=%h", bus.LO, 32'd0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_arith(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int lat,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc; bit ov;
    do_op(op, a, b, cyc, ov);
    total++; if (cyc !== lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, lat); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL %s_busy_done_overlap got=1 want=0", name); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", name, bus.done); end
    total++; if (bus.HI !== exp_hi) begin bad++; $display("FAIL %s_hi got=%h want=%h", name, bus.HI, exp_hi); end
    total++; if (bus.LO !== exp_lo) begin bad++; $display("FAIL %s_lo got=%h want=%h", name, bus.LO, exp_lo); end
    @(posedge clock); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got=%b want=0", name, bus.done); end
  endtask

  task automatic test_mult;
    test_arith("mult_neg",   3'b000, 32'hFFFF_FFFD, 32'd7,        MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    test_arith("mult_minsq", 3'b000, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 32'h0000_0000);
    test_arith("multu_max",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_div;
    test_arith("div_neg",  3'b010, 32'hFFFF_FFF9, 32'd2,         DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_arith("div_negb", 3'b010, 32'd7,         32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD);
    test_arith("divu",     3'b011, 32'd100,       32'd7,         DIV_LAT, 32'd2,         32'd14);
  endtask

  task automatic test_div_boundary;
    test_arith("div_zero",  3'b010, 32'h0000_1234, 32'd0,         DIV_LAT, 32'h0000_1234, 32'hFFFF_FFFF);
    test_arith("div_zeron", 3'b010, 32'hFFFF_FFF9, 32'd0,         DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    test_arith("divu_zero", 3'b011, 32'hDEAD_BEEF, 32'd0,         DIV_LAT, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    test_arith("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000);
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] lo_before;
    lo_before = bus.LO;
    bus.start = 1'b1; bus.OP = 3'b100; bus.A = 32'd5;
    @(posedge clock); #1;
    bus.start = 1'b0;
    total++; if (bus.HI !== 32'd5) begin bad++; $display("FAIL mthi_hi got=%h want=%h", bus.HI, 32'd5); end
    total++; if (bus.LO !== lo_before) begin bad++; $display("FAIL mthi_lo got=%h want=%h", bus.LO, lo_before); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mthi_done got=%b want=0", bus.done); end
    bus.start = 1'b1; bus.OP = 3'b101; bus.A = 32'hCAFE_0009;
    @(posedge clock); #1;
    bus.start = 1'b0;
    total++; if (bus.LO !== 32'hCAFE_0009) begin bad++; $display("FAIL mtlo_lo got=%h want=%h", bus.LO, 32'hCAFE_0009); end
    total++; if (bus.HI !== 32'd5) begin bad++; $display("FAIL mtlo_hi got=%h want=%h", bus.HI, 32'd5); end
    bus.start = 1'b1; bus.OP = 3'b110; bus.A = 32'h1111_1111; bus.B = 32'd3;
    @(posedge clock); #1;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reserved_busy got=%b want=0", bus.busy); end
    total++; if (bus.HI !== 32'd5) begin bad++; $display("FAIL reserved_hi got=%h want=%h", bus.HI, 32'd5); end
    total++; if (bus.LO !== 32'hCAFE_0009) begin bad++; $display("FAIL reserved_lo got=%h want=%h", bus.LO, 32'hCAFE_0009); end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    bus.start = 1'b1; bus.OP = 3'b010; bus.A = 32'hFFFF_FF9C; bus.B = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    bus.start = 1'b1; bus.OP = 3'b001; bus.A = 32'd3; bus.B = 32'd5;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc = 10;
    while (bus.busy && cyc < 200) begin cyc++; @(posedge clock); #1; end
    total++; if (cyc !== 33) begin bad++; $display("FAIL busy_ignore_latency got=%0d want=33", cyc); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL busy_ignore_done got=%b want=1", bus.done); end
    total++; if (bus.LO !== 32'hFFFF_FFF2) begin bad++; $display("FAIL busy_ignore_lo got=%h want=%h", bus.LO, 32'hFFFF_FFF2); end
    total++; if (bus.HI !== 32'hFFFF_FFFE) begin bad++; $display("FAIL busy_ignore_hi got=%h want=%h", bus.HI, 32'hFFFF_FFFE); end
    @(posedge clock); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_noqueue got=%b want=0", bus.busy); end
  endtask

  task automatic test_start_in_fix;
    int cyc;
    bus.start = 1'b1; bus.OP = 3'b011; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      if (cyc == 32) begin
        bus.start = 1'b1; bus.OP = 3'b001; bus.A = 32'd3; bus.B = 32'd5;
      end
      cyc++;
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
    total++; if (cyc !== 33) begin bad++; $display("FAIL fix_start_latency got=%0d want=33", cyc); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL fix_start_busy got=%b want=0", bus.busy); end
    total++; if (bus.LO !== 32'd14) begin bad++; $display("FAIL fix_start_lo got=%h want=%h", bus.LO, 32'd14); end
    @(posedge clock); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL fix_start_ignored got=%b want=0", bus.busy); end
    total++; if (bus.HI !== 32'd2) begin bad++; $display("FAIL fix_start_hi got=%h want=%h", bus.HI, 32'd2); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit ov;
    do_op(3'b011, 32'd1000, 32'd9, cyc, ov);
    total++; if (bus.LO !== 32'd111) begin bad++; $display("FAIL b2b_first_lo got=%h want=%h", bus.LO, 32'd111); end
    do_op(3'b001, 32'h0001_0000, 32'h0001_0000, cyc, ov);
    total++; if (cyc !== MUL_LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", cyc, MUL_LAT); end
    total++; if (bus.HI !== 32'd1) begin bad++; $display("FAIL b2b_hi got=%h want=%h", bus.HI, 32'd1); end
    total++; if (bus.LO !== 32'd0) begin bad++; $display("FAIL b2b_lo got=%h want=%h", bus.LO, 32'd0); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_op;
    bit saw_done;
    bus.start = 1'b1; bus.OP = 3'b000; bus.A = 32'hFFFF_FFFD; bus.B = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (19) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(posedge clock); #1;
    total++; if (bus.HI !== 32'd0) begin bad++; $display("FAIL midreset_hi got=%h want=%h", bus.HI, 32'd0); end
    total++; if (bus.LO !== 32'd0) begin bad++; $display("FAIL midreset_lo got=%h want=%h", bus.LO, 32'd0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", bus.busy); end
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midreset_no_done got=1 want=0"); end
    total++; if (bus.LO !== 32'd0) begin bad++; $display("FAIL midreset_lo_held got=%h want=%h", bus.LO, 32'd0); end
  endtask

  initial begin
    total = 0; bad = 0;
    bus.start = 1'b0; bus.OP = 3'b000; bus.A = 32'd0; bus.B = 32'd0;
    reset = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_div_boundary;
    test_mthi_mtlo;
    test_start_while_busy;
    test_start_in_fix;
    test_back_to_back;
    test_reset_mid_op;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS execute stage, sitting beside and downstream of the 32-bit ALU on the same A/B operand buses. It executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers and services MTHI/MTLO. HI/LO are read back through the writeback mux. A busy/done handshake lets the pipeline control stall on MFHI/MFLO and on a new mult/div while an operation is in flight.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `start` in 1: one-cycle request pulse; sampled only in IDLE.
- `OP` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x reserved (no-op).
- `A` in 32: multiplicand / dividend / MTHI-MTLO source.
- `B` in 32: multiplier / divisor.
- `HI` out 32: HI register (product high word / remainder).
- `LO` out 32: LO register (product low word / quotient).
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when HI/LO hold a new mult/div result.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, OP in 000–011:
  - latch operands; signed ops latch |A|, |B| and the result sign bits;
  - clear iteration counter;
  - go to RUN.
- IDLE, `start`=1, OP 100/101: write `A` to HI/LO; stay IDLE; no `done` pulse.
- IDLE, `start`=1, OP 11x: ignored.
- RUN: one iteration per cycle, 32 iterations, then FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
- FIX:
  - apply sign correction;
  - write HI/LO;
  - pulse `done`;
  - return to IDLE.
- Signed multiply: 64-bit product negated when sign(A)≠sign(B).
- Signed divide:
  - quotient negated when signs differ;
  - remainder takes the sign of the dividend (truncating division).
- Divide by zero (DIV or DIVU): LO=32'hFFFFFFFF, HI=A, full normal latency.
- DIV overflow (A=32'h80000000, B=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- `start` while `busy`=1: ignored, no queueing. Pipeline control must stall.
- `A`/`B` changes after the start cycle have no effect.
- HI/LO keep their old value until FIX; intermediate state is internal only.

## Timing
- Reset values: HI=0, LO=0, busy=0, done=0, state IDLE, counter 0.
- Reset mid-operation: abort, all of the above restored on that edge, result discarded.
- Start sampled at edge k:
  - `busy`=1 after edge k through edge k+32 (33 cycles);
  - RUN occupies edges k+1..k+32; FIX at edge k+33.
- After edge k+33:
  - HI/LO updated and `done`=1 for exactly one cycle;
  - `busy`=0;
  - a new `start` may be sampled at edge k+34, or at edge k+33 if `start` is already asserted in the FIX cycle is NOT accepted.
- MTHI/MTLO: written at the sampling edge, visible the next cycle; `busy` stays 0.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `MULDIV_FAST_MULT_EN` defined:
  - MULT/MULTU skip RUN and compute the product with a single-cycle multiplier;
  - start sampled at edge k gives FIX at edge k+1, then `done` and the result after edge k+1;
  - `busy` is high for 1 cycle.
  - DIV/DIVU unchanged (33-cycle busy).
- `MULDIV_FAST_MULT_EN` undefined: all four operations use the iterative 33-cycle path.
- Results are bit-identical in both builds.

## Test plan
- Reset then idle: `reset`=0 for 2 cycles -> HI=LO=0, busy=0, done=0.
- MULT A=-3 (32'hFFFFFFFD), B=7 -> after 33 busy cycles, done pulse; HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001. Repeat with `MULDIV_FAST_MULT_EN` -> same values, busy for 1 cycle.
- DIV A=-7, B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). DIVU A=100, B=7 -> LO=14, HI=2.
- Boundary cases:
  - DIV A=32'h1234, B=0 -> LO=32'hFFFFFFFF, HI=32'h1234;
  - DIV A=32'h80000000, B=-1 -> LO=32'h80000000, HI=0;
  - MTHI A=5 -> HI=5 next cycle, no done.
- Interference:
  - `start` with MULTU pulsed at cycle 10 of a DIV -> ignored, DIV result correct;
  - `reset` low at cycle 20 of a MULT -> HI=LO=0, busy=0, no done pulse.
